// File: rtl/stream_fifo_rr_arbiter.sv
// Purpose: round-robin, packet-locked arbiter merging NUM_REQ beat streams onto one FIFO write port.
// Latency: zero cycles; the winning beat passes combinationally and can be written in the cycle it appears.
// Backpressure: w_ready_i is routed only to the granted requester; the grant holds through stalls and bubbles until last.
module stream_fifo_rr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BEATS  = 16,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(MAX_BEATS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  output logic [DATA_WIDTH-1:0]         w_data_o,
  output logic [ID_W-1:0]               w_src_o,
  output logic                          busy_o,
  output logic [CNT_W-1:0]              beat_cnt_o,
  output logic                          err_o,
  input  logic                          err_clr_i
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  win_found;
  logic [ID_W-1:0]       win_idx;
  logic [ID_W-1:0]       scan_idx;
  int                    scan_pos;
  logic [ID_W-1:0]       sel;
  logic                  offer;
  logic                  hs;
  logic                  sel_last;
  logic                  oversize;

  // Split the flat data bus into one lane per requester.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Find the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_pos = (int'(rr_ptr_q) + i) % NUM_REQ;
      scan_idx = ID_W'(scan_pos);
      if (!win_found && req_valid_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Connect the selected requester to the write port; outputs are forced quiet while in reset.
  always_comb begin
    sel         = (state_q == IDLE && win_found) ? win_idx : owner_q;
    offer       = (state_q == IDLE) ? win_found : req_valid_i[owner_q];
    w_valid_o   = offer & ~rst;
    w_data_o    = data_arr[sel];
    w_src_o     = rst ? '0 : sel;
    req_ready_o = '0;
    if (!rst && (state_q == LOCKED || win_found)) begin
      req_ready_o[sel] = w_ready_i;
    end
    hs       = w_valid_o & w_ready_i;
    sel_last = req_last_i[sel];
    oversize = hs && !sel_last && (beat_cnt_q == CNT_LIMIT);
  end

  // Next-state logic: lock on any offered non-final beat, release on the accepted last beat.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          if (hs && sel_last) begin
            rr_ptr_d = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
          end else begin
            state_d = LOCKED;
            owner_d = win_idx;
            if (hs) beat_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        if (hs) begin
          if (sel_last) begin
            state_d    = IDLE;
            rr_ptr_d   = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
            beat_cnt_d = '0;
          end else if (beat_cnt_q != CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new oversize event takes priority over a simultaneous clear.
    if (oversize)       err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign busy_o     = (state_q == LOCKED);
  assign beat_cnt_o = beat_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_stream_fifo_rr_arbiter.sv
// Bench for stream_fifo_rr_arbiter: directed scenarios plus random traffic.
// A packet-level reference model predicts every accepted beat into a queue;
// a negedge monitor pops and compares whenever the DUT completes a write.
module tb_stream_fifo_rr_arbiter;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXB = 16;
  localparam int IDW  = 2;
  localparam int CW   = 5;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    int            cnt;
    bit            busy;
    bit            err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    vld, lst, rdy;
  logic [N*DW-1:0] dat;
  logic            wr, clr;
  logic            w_valid, busy, err;
  logic [DW-1:0]   w_data;
  logic [IDW-1:0]  w_src;
  logic [CW-1:0]   bcnt;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [N-1:0] mon_oh;

  // Reference model: who holds the port (-1 = nobody), next search start, beats in packet, sticky error.
  int m_owner, m_ptr, m_cnt;
  bit m_err;

  int            rem [N];
  logic [DW-1:0] cd  [N];
  int            h;

  always #5 clk = ~clk;

  stream_fifo_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(vld), .req_ready_o(rdy), .req_data_i(dat), .req_last_i(lst),
    .w_valid_o(w_valid), .w_ready_i(wr), .w_data_o(w_data), .w_src_o(w_src),
    .busy_o(busy), .beat_cnt_o(bcnt), .err_o(err), .err_clr_i(clr)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
  endtask

  // Predict this cycle's outcome from the current inputs and advance the model.
  task automatic model_eval(output int hs_src);
    int   src;
    int   j;
    bit   v, hsk, set;
    exp_t e;
    src = -1;
    v   = 1'b0;
    set = 1'b0;
    if (m_owner >= 0) begin
      src = m_owner;
      v   = vld[src];
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (src < 0 && vld[j]) begin
          src = j;
          v   = 1'b1;
        end
      end
    end
    hsk    = v && wr;
    hs_src = hsk ? src : -1;
    if (hsk) begin
      e.src  = src;
      e.data = dat[src*DW +: DW];
      e.cnt  = m_cnt;
      e.busy = (m_owner >= 0);
      e.err  = m_err;
      q.push_back(e);
    end
    if (src >= 0) begin
      if (hsk && lst[src]) begin
        m_owner = -1;
        m_ptr   = (src + 1) % N;
        m_cnt   = 0;
      end else begin
        m_owner = src;
        if (hsk) begin
          if (m_cnt == MAXB - 1) set = 1'b1;
          m_cnt = (m_cnt < MAXB) ? m_cnt + 1 : MAXB;
        end
      end
    end
    if (set)      m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_neg();
    model_eval(h);
    @(negedge clk);
  endtask

  task automatic set_dat(input int k, input logic [DW-1:0] v);
    dat[k*DW +: DW] = v;
  endtask

  task automatic do_reset();
    vld = '0; lst = '0; wr = 1'b0; clr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: every DUT write must match the oldest predicted beat.
  always @(negedge clk) begin
    if (!rst && w_valid && wr) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: src %0d data %0h with no predicted beat", w_src, w_data);
      end else begin
        mon_e = q.pop_front();
        mon_oh = '0;
        mon_oh[mon_e.src] = 1'b1;
        chk("sb_src",   w_src,  mon_e.src);
        chk("sb_data",  w_data, mon_e.data);
        chk("sb_cnt",   bcnt,   mon_e.cnt);
        chk("sb_busy",  busy,   mon_e.busy);
        chk("sb_err",   err,    mon_e.err);
        chk("sb_ready", rdy,    mon_oh);
      end
    end
  end

  initial begin
    rst = 1'b1; vld = '0; lst = '0; dat = '0; wr = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", w_valid, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_src",   w_src, 0);
    chk("rst_cnt",   bcnt, 0);
    chk("rst_err",   err, 0);
    rst = 1'b0;
    model_reset();

    // Fairness: all requesters streaming single-beat packets.
    vld = '1; lst = '1; wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) set_dat(k, $urandom);
      step_neg();
      chk("fair_src", w_src, i % N);
      chk("fair_valid", w_valid, 1);
      tick();
    end

    // Packet lock: req0 sends 4 beats while req1 waits.
    for (int i = 0; i < 5; i++) begin
      vld = (i < 4) ? 4'b0011 : 4'b0010;
      lst = (i == 3) ? 4'b0011 : 4'b0010;
      set_dat(0, $urandom);
      set_dat(1, 32'h1111_0000 + i);
      step_neg();
      chk("lock_src",  w_src, (i < 4) ? 0 : 1);
      chk("lock_cnt",  bcnt, (i < 4) ? i : 0);
      chk("lock_busy", busy, (i > 0 && i < 4) ? 1 : 0);
      tick();
    end
    vld = '0; lst = '0;

    // Stall stability: req2 waits through 3 stalled cycles, req0 arrives meanwhile.
    set_dat(2, 32'hC0DE_0002);
    set_dat(0, 32'hC0DE_0000);
    for (int i = 0; i < 5; i++) begin
      vld = (i == 0) ? 4'b0100 : (i < 4 ? 4'b0101 : 4'b0001);
      lst = 4'b0101;
      wr  = (i >= 3);
      step_neg();
      if (i < 4) begin
        chk("stall_src",   w_src, 2);
        chk("stall_data",  w_data, 32'hC0DE_0002);
        chk("stall_valid", w_valid, 1);
        chk("stall_busy",  busy, (i > 0) ? 1 : 0);
      end else begin
        chk("stall_next_src", w_src, 0);
      end
      tick();
    end
    vld = '0; lst = '0; wr = 1'b1;

    // Bubble in lock: req1 goes quiet mid-packet while req3 waits.
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 3, 4: vld = 4'b1010;
        default: vld = (i == 5) ? 4'b1000 : 4'b1000;
      endcase
      lst = (i == 4) ? 4'b1010 : 4'b1000;
      set_dat(1, $urandom);
      set_dat(3, 32'h3333_3333);
      step_neg();
      if (i == 1 || i == 2) begin
        chk("bubble_valid", w_valid, 0);
        chk("bubble_rdy3",  rdy[3], 0);
        chk("bubble_busy",  busy, 1);
      end else begin
        chk("bubble_src", w_src, (i == 5) ? 3 : 1);
      end
      tick();
    end
    vld = '0; lst = '0;

    // Oversize: a 17-beat packet from req0.
    for (int b = 0; b <= MAXB; b++) begin
      vld = 4'b0001;
      lst = (b == MAXB) ? 4'b0001 : 4'b0000;
      set_dat(0, $urandom);
      step_neg();
      if (b == MAXB - 1) chk("ovs_err_before", err, 0);
      if (b == MAXB) begin
        chk("ovs_err_set", err, 1);
        chk("ovs_cnt_sat", bcnt, MAXB);
      end
      tick();
    end
    vld = '0; lst = '0;
    step_neg();
    chk("ovs_err_sticky", err, 1);
    chk("ovs_idle", busy, 0);
    tick();
    clr = 1'b1;
    step_neg();
    chk("ovs_err_clr_same", err, 1);
    tick();
    clr = 1'b0;
    step_neg();
    chk("ovs_err_cleared", err, 0);
    tick();

    // Random traffic with bubbles, stalls, occasional long packets and clears.
    for (int k = 0; k < N; k++) begin
      rem[k] = 0;
      cd[k]  = $urandom;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (rem[k] == 0 && $urandom_range(0, 3) == 0)
          rem[k] = ($urandom_range(0, 30) == 0) ? int'($urandom_range(15, 20)) : int'($urandom_range(1, 6));
        vld[k] = (rem[k] > 0) && ($urandom_range(0, 4) != 0);
        lst[k] = (rem[k] == 1);
        set_dat(k, cd[k]);
      end
      wr  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      model_eval(h);
      if (h >= 0) begin
        rem[h] = rem[h] - 1;
        cd[h]  = $urandom;
      end
      tick();
    end

    // Reset mid-packet: req1 is aborted during its third beat.
    do_reset();
    vld = 4'b0010; lst = '0; wr = 1'b1;
    for (int b = 0; b < 2; b++) begin
      set_dat(1, $urandom);
      step_neg();
      tick();
    end
    set_dat(1, $urandom);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", w_valid, 0);
    chk("rstmid_ready", rdy, 0);
    chk("rstmid_busy",  busy, 0);
    chk("rstmid_cnt",   bcnt, 0);
    tick();
    rst = 1'b0;
    model_reset();
    vld = 4'b0011; lst = 4'b0011;
    step_neg();
    chk("rstmid_restart0", w_src, 0);
    tick();
    step_neg();
    chk("rstmid_restart1", w_src, 1);
    tick();

    vld = '0; lst = '0; wr = 1'b0; clr = 1'b0;
    tick();
    tick();
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_fifo_rr_arbiter.md
Name: stream_fifo_rr_arbiter

Overview:
- Round-robin, packet-locked write arbiter that lets NUM_REQ producers share one SRAM-backed stream FIFO write port.
- Sits directly in front of the FIFO write side; its ready/valid output connects to the FIFO's w_valid/w_ready.
- Once a packet's first beat is offered, it holds the grant until that packet's last beat is accepted, so packets never interleave in the FIFO.
- Reports the winning source ID, counts beats per packet, and flags oversize packets.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- DATA_WIDTH, 32, beat width.
- MAX_BEATS, 16, maximum legal beats per packet; must be >= 2.
- ID_W, $clog2(NUM_REQ), width of the source ID (derived, not overridable).
- CNT_W, $clog2(MAX_BEATS+1), width of the beat counter (derived).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_ready_o  out  NUM_REQ  per-requester beat accepted.
- req_data_i  in  NUM_REQ*DATA_WIDTH  requester k's data in bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  per-requester last beat of packet.
- w_valid_o  out  1  FIFO write valid.
- w_ready_i  in  1  FIFO write ready.
- w_data_o  out  DATA_WIDTH  FIFO write data.
- w_src_o  out  ID_W  index of the currently granted requester.
- busy_o  out  1  high while in LOCKED.
- beat_cnt_o  out  CNT_W  beats accepted so far in the current packet.
- err_o  out  1  sticky oversize-packet flag.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, err=0.
- Reset outputs: w_valid_o=0, req_ready_o=0, busy_o=0, w_src_o=0, beat_cnt_o=0, err_o=0.
- Reset asserted mid-packet aborts the packet immediately. The partial packet already in the FIFO is the system's responsibility.
- State IDLE:
  - winner = first k with req_valid_i[k]=1, searching from rr_ptr upward modulo NUM_REQ.
  - If any requester is valid: w_valid_o=1, w_data_o and w_src_o come from the winner, req_ready_o[winner]=w_ready_i, all other ready bits 0.
  - If no requester is valid: w_valid_o=0, all ready bits 0, w_src_o holds owner.
  - Zero-cycle arbitration: the first beat can be written in the cycle its request appears.
- IDLE transitions, when a winner exists:
  - Handshake with last=1: single-beat packet. Stay IDLE, rr_ptr <= winner+1 (mod NUM_REQ), beat_cnt stays 0.
  - Any other case (handshake with last=0, or no handshake): go to LOCKED, owner <= winner.
  - If a handshake occurred, beat_cnt <= 1; otherwise it stays 0.
  - Purpose: w_valid_o and w_data_o stay stable while the FIFO stalls. A higher-priority requester arriving during a stall cannot steal the port.
- State LOCKED:
  - Only owner is connected: w_valid_o=req_valid_i[owner], req_ready_o[owner]=w_ready_i, other ready bits 0, w_src_o=owner.
  - Owner dropping valid mid-packet is a legal bubble; the grant is held.
  - Handshake with last=1: go to IDLE, rr_ptr <= owner+1 (mod NUM_REQ), beat_cnt <= 0.
  - Handshake with last=0: beat_cnt <= beat_cnt+1, saturating at MAX_BEATS.
- busy_o = (state==LOCKED).
- Oversize error:
  - Triggers on a handshake with last=0 when beat_cnt==MAX_BEATS-1, i.e. the packet has passed MAX_BEATS beats without last.
  - Sets err (sticky). Data continues to flow, the grant is held, and the arbiter does not force a release.
  - err_clr_i clears err the following cycle. If set and clear occur in the same cycle, set wins.
- Modulo wrap: rr_ptr wraps from NUM_REQ-1 to 0. For non-power-of-two NUM_REQ, ID_W-bit values >= NUM_REQ are never produced.
- The arbiter stores no data; all data paths are combinational muxes from the requester inputs.

Test Plan:
- Fairness: NUM_REQ=4, all four valid with continuous single-beat packets, w_ready_i=1 -> w_src_o sequence 0,1,2,3,0,1,... with one beat per cycle and no bubbles.
- Packet lock: req0 sends a 4-beat packet while req1 is valid throughout -> 4 consecutive beats with src=0, then req1's beat; beat_cnt_o 1,2,3 then 0; busy_o high for the middle cycles.
- Stall stability: req2 alone valid, w_ready_i=0 for 3 cycles, req0 asserts in cycle 2 -> w_src_o stays 2, w_data_o unchanged, busy_o=1; on w_ready_i=1, req2's beat is accepted before req0's.
- Bubble in lock: owner req1 drops valid for 2 cycles mid-packet while req3 is valid -> w_valid_o=0 and req_ready_o[3]=0 during the gap; req1 resumes and finishes its packet before req3 starts.
- Oversize: MAX_BEATS=16, a 17-beat packet -> err_o rises the cycle after the 16th beat (no last) is accepted; pulsing err_clr_i clears it.
- Reset mid-packet: assert rst during beat 3 -> w_valid_o, req_ready_o, busy_o and beat_cnt_o are 0 immediately; after release, arbitration restarts from rr_ptr=0.
